// File: rtl/mod_148_dplca_txop_table.sv
// DPLCA transmit-opportunity table and node-count scheduler.
// Tracks a per-ID age counter from the claim reports that the PLCA control
// FSM gives at the end of each TXOP. At the end of each PLCA cycle it scans
// the table to recompute plca_node_count. It then raises dplca_txop_table_upd
// to release the control FSM.
// Optional build macro: DPLCA_SOFT_CLAIM_EN. When it is defined, a SOFT claim
// refreshes a live entry to AGE_MAX. When it is undefined, SOFT behaves as NONE.
module mod_148_dplca_txop_table #(
  parameter int AGE_MAX        = 8,
  parameter int AGE_W          = 4,
  parameter int MIN_NODE_COUNT = 8
) (
  input  logic       clk,
  input  logic       plca_reset,
  input  logic       dplca_en,
  input  logic [1:0] dplca_txop_claim,
  input  logic       dplca_txop_end,
  input  logic [7:0] dplca_txop_id,
  input  logic [7:0] dplca_txop_node_count,
  output logic       dplca_txop_table_upd,
  output logic       dplca_aging,
  output logic [7:0] plca_node_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0]       CLAIM_SOFT = 2'b01;
  localparam logic [1:0]       CLAIM_HARD = 2'b11;
  localparam logic [AGE_W-1:0] AGE_LOAD   = AGE_W'(AGE_MAX);
  localparam logic [8:0]       MIN_CNT9   = 9'(MIN_NODE_COUNT);
  localparam logic [7:0]       MIN_CNT8   = 8'(MIN_NODE_COUNT);

  // The age table is held in flops, not block RAM. It must clear in a single
  // cycle on reset, and the same entry is read and rewritten within one cycle.
  logic [AGE_W-1:0] ages_reg [256];

  state_t           state_reg;
  logic             end_prev_reg;
  logic [7:0]       id_reg;
  logic [1:0]       claim_reg;
  logic [7:0]       ptr_reg;
  logic             scan_ran_reg;
  logic [7:0]       count_reg;
  logic             upd_reg;
  logic             aging_reg;
  logic [7:0]       node_count_reg;

  logic             clear_all;
  logic [AGE_W-1:0] age_at_id;
  logic [AGE_W-1:0] age_at_ptr;
  logic [AGE_W-1:0] age_dec;
  logic [AGE_W-1:0] age_next;
  logic [8:0]       id_plus1;
  logic             end_of_cycle;
  logic [8:0]       ptr_plus1;
  logic [8:0]       cnt9;
  logic [7:0]       scan_count;

  // A disabled table behaves exactly like one held in reset.
  assign clear_all  = plca_reset | ~dplca_en;
  assign age_at_id  = ages_reg[id_reg];
  assign age_at_ptr = ages_reg[ptr_reg];

  // New value for the entry selected by the captured ID.
  always_comb begin
    age_dec  = (age_at_id == '0) ? '0 : age_at_id - 1'b1;
    age_next = age_dec;
    case (claim_reg)
      CLAIM_HARD: age_next = AGE_LOAD;
`ifdef DPLCA_SOFT_CLAIM_EN
      // SOFT can keep a live node alive, but it can never revive a dead one.
      CLAIM_SOFT: age_next = (age_at_id != '0) ? AGE_LOAD : '0;
`else
      CLAIM_SOFT: age_next = age_dec;
`endif
      default:    age_next = age_dec;
    endcase
  end

  // Detect the end of a PLCA cycle, and saturate the count found by the scan.
  always_comb begin
    id_plus1     = {1'b0, id_reg} + 9'd1;
    end_of_cycle = (id_reg == 8'hFF) || (id_plus1 >= {1'b0, dplca_txop_node_count});
    ptr_plus1    = {1'b0, ptr_reg} + 9'd1;
    cnt9         = (ptr_plus1 < MIN_CNT9) ? MIN_CNT9 : ptr_plus1;
    scan_count   = (cnt9 > 9'd255) ? 8'hFF : cnt9[7:0];
  end

  // Age table: clear on reset, and write the captured entry in UPDATE.
  always_ff @(posedge clk) begin
    if (clear_all) begin
      for (int i = 0; i < 256; i++) begin
        ages_reg[i] <= '0;
      end
    end else if (state_reg == ST_UPDATE) begin
      ages_reg[id_reg] <= age_next;
    end
  end

  // Control FSM: capture, update, optional descending scan, then handshake.
  always_ff @(posedge clk) begin
    // Keep tracking txop_end in reset so a level held across reset release
    // does not look like a fresh edge.
    end_prev_reg <= dplca_txop_end;
    if (clear_all) begin
      state_reg      <= ST_IDLE;
      id_reg         <= '0;
      claim_reg      <= 2'b10;
      ptr_reg        <= '0;
      scan_ran_reg   <= 1'b0;
      count_reg      <= MIN_CNT8;
      upd_reg        <= 1'b0;
      aging_reg      <= 1'b0;
      node_count_reg <= MIN_CNT8;
    end else begin
      aging_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          upd_reg <= 1'b0;
          if (dplca_txop_end && !end_prev_reg) begin
            id_reg    <= dplca_txop_id;
            claim_reg <= dplca_txop_claim;
            state_reg <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          scan_ran_reg <= 1'b0;
          if (end_of_cycle) begin
            ptr_reg   <= 8'hFF;
            state_reg <= ST_SCAN;
          end else begin
            state_reg <= ST_DONE;
          end
        end
        ST_SCAN: begin
          if (age_at_ptr != '0) begin
            count_reg    <= scan_count;
            scan_ran_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else if (ptr_reg == 8'd0) begin
            count_reg    <= MIN_CNT8;
            scan_ran_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else begin
            ptr_reg <= ptr_reg - 8'd1;
          end
        end
        ST_DONE: begin
          if (!upd_reg) begin
            upd_reg <= 1'b1;
            if (scan_ran_reg) begin
              node_count_reg <= count_reg;
            end
          end else if (!dplca_txop_end) begin
            upd_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dplca_txop_table_upd = upd_reg;
  assign dplca_aging          = aging_reg;
  assign plca_node_count      = node_count_reg;
  assign busy                 = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mod_148_dplca_txop_table.sv
// Bench for mod_148_dplca_txop_table. It uses a queue-based scoreboard against
// an age-table model. Each TXOP pushes its expected upd latency and node count.
// A negedge monitor pops that entry on every rising edge of upd and checks it.
module tb_mod_148_dplca_txop_table;

  localparam int AGE_MAX = 8;
  localparam int MIN_NC  = 8;

  logic       clk = 1'b0;
  logic       plca_reset;
  logic       dplca_en;
  logic [1:0] dplca_txop_claim;
  logic       dplca_txop_end;
  logic [7:0] dplca_txop_id;
  logic [7:0] dplca_txop_node_count;
  logic       dplca_txop_table_upd;
  logic       dplca_aging;
  logic [7:0] plca_node_count;
  logic       busy;

  mod_148_dplca_txop_table #(.AGE_MAX(AGE_MAX), .AGE_W(4), .MIN_NODE_COUNT(MIN_NC)) dut (
    .clk                   (clk),
    .plca_reset            (plca_reset),
    .dplca_en              (dplca_en),
    .dplca_txop_claim      (dplca_txop_claim),
    .dplca_txop_end        (dplca_txop_end),
    .dplca_txop_id         (dplca_txop_id),
    .dplca_txop_node_count (dplca_txop_node_count),
    .dplca_txop_table_upd  (dplca_txop_table_upd),
    .dplca_aging           (dplca_aging),
    .plca_node_count       (plca_node_count),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: ages per ID and the published node count.
  int ages[256];
  int pub_count = MIN_NC;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) ages[i] = 0;
    pub_count = MIN_NC;
  endfunction

  // Apply one TXOP to the model, and return the expected latency and count.
  function automatic exp_t model_txop(input int id, input logic [1:0] claim, input int n);
    exp_t e;
    int   k;
    if (claim == 2'b11) begin
      ages[id] = AGE_MAX;
    end else if (claim == 2'b01) begin
`ifdef DPLCA_SOFT_CLAIM_EN
      if (ages[id] > 0) ages[id] = AGE_MAX;
`else
      if (ages[id] > 0) ages[id] = ages[id] - 1;
`endif
    end else begin
      if (ages[id] > 0) ages[id] = ages[id] - 1;
    end
    e.lat = 2;
    if (id == 255 || id + 1 >= n) begin
      k = -1;
      for (int i = 255; i >= 0; i--) begin
        if (ages[i] > 0) begin
          k = i;
          break;
        end
      end
      if (k < 0) begin
        pub_count = MIN_NC;
        e.lat     = 2 + 256;
      end else begin
        pub_count = (k + 1 < MIN_NC) ? MIN_NC : ((k + 1 > 255) ? 255 : k + 1);
        e.lat     = 2 + 256 - k;
      end
    end
    e.cnt = pub_count;
    return e;
  endfunction

  // Monitor: time each txop_end rise, and score each rising edge of upd.
  int   start_cyc = 0;
  logic mon_end_prev = 1'b0;
  logic mon_upd_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (dplca_txop_end && !mon_end_prev) start_cyc = cyc + 1;
    mon_end_prev = dplca_txop_end;
    if (dplca_txop_table_upd && !mon_upd_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_upd", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("upd_latency", cyc - start_cyc, e.lat);
        check("node_count", int'(plca_node_count), e.cnt);
      end
    end
    mon_upd_prev = dplca_txop_table_upd;
  end

  // One TXOP handshake. The caller is aligned to posedge+1. The task holds
  // txop_end for `hold` extra cycles after upd, then releases it.
  task automatic do_txop(input int id, input logic [1:0] claim, input int n, input int hold);
    int w;
    exp_q.push_back(model_txop(id, claim, n));
    dplca_txop_id         = 8'(id);
    dplca_txop_claim      = claim;
    dplca_txop_node_count = 8'(n);
    dplca_txop_end        = 1'b1;
    w = 0;
    while (!dplca_txop_table_upd && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (!dplca_txop_table_upd) begin
      check("upd_timeout", 0, 1);
      exp_q.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("upd_held", int'(dplca_txop_table_upd), 1);
    end
    dplca_txop_end = 1'b0;
    @(posedge clk); #1;
    check("upd_drop", int'(dplca_txop_table_upd), 0);
    check("idle_after", int'(busy), 0);
  endtask

  function automatic logic [1:0] rand_claim();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 2'b10;
    if (r < 5) return 2'b00;
    if (r < 8) return 2'b01;
    return 2'b11;
  endfunction

  // One PLCA cycle over IDs 0..N-1, where N is the current count. Up to two
  // IDs get the given claims; every other ID reports NONE.
  task automatic run_cycle(input int h1, input logic [1:0] c1, input int h2, input logic [1:0] c2);
    int n;
    n = pub_count;
    for (int id = 0; id < n; id++) begin
      do_txop(id, (id == h1) ? c1 : ((id == h2) ? c2 : 2'b10), n, 0);
    end
  endtask

  initial begin
    model_reset();
    plca_reset            = 1'b1;
    dplca_en              = 1'b1;
    dplca_txop_claim      = 2'b10;
    dplca_txop_end        = 1'b0;
    dplca_txop_id         = 8'd0;
    dplca_txop_node_count = 8'd8;
    repeat (3) @(posedge clk);
    #1;
    check("rst_upd", int'(dplca_txop_table_upd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(plca_node_count), MIN_NC);
    check("rst_aging", int'(dplca_aging), 0);
    plca_reset = 1'b0;
    @(posedge clk); #1;
    check("aging_on", int'(dplca_aging), 1);

    // HARD on id 12, then a NONE cycle 0..7 with a node count of 8.
    do_txop(12, 2'b11, 8, 0);
    for (int id = 0; id < 8; id++) do_txop(id, 2'b10, 8, 0);

    // Eight cycles with no claim on id 12 age it out.
    for (int c = 0; c < 8; c++) run_cycle(-1, 2'b10, -1, 2'b10);

    // SOFT on a live entry (age 3) and on a dead entry.
    do_txop(20, 2'b11, pub_count, 0);
    for (int c = 0; c < 5; c++) run_cycle(-1, 2'b10, -1, 2'b10);
    run_cycle(20, 2'b01, -1, 2'b10);
    do_txop(30, 2'b01, pub_count, 0);
    for (int c = 0; c < 9; c++) run_cycle(-1, 2'b10, -1, 2'b10);

    // Hold txop_end for 5 cycles after upd.
    do_txop(3, 2'b11, pub_count, 5);

    // HARD on id 255 saturates the count at 255.
    do_txop(255, 2'b11, 8, 0);
    dplca_en = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("dis_count", int'(plca_node_count), MIN_NC);
    check("dis_aging", int'(dplca_aging), 0);
    check("dis_busy", int'(busy), 0);
    dplca_en = 1'b1;
    @(posedge clk); #1;

    // Reset while the scan pointer is at 100. A live entry at 50 must not
    // survive the reset.
    do_txop(50, 2'b11, 8, 0);
    dplca_txop_id         = 8'd7;
    dplca_txop_claim      = 2'b10;
    dplca_txop_node_count = 8'd8;
    dplca_txop_end        = 1'b1;
    repeat (157) @(posedge clk);
    #1;
    check("scan_busy", int'(busy), 1);
    plca_reset     = 1'b1;
    dplca_txop_end = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("mid_rst_upd", int'(dplca_txop_table_upd), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_count", int'(plca_node_count), MIN_NC);
    plca_reset = 1'b0;
    @(posedge clk); #1;
    do_txop(7, 2'b10, 8, 0);

    // Randomized cycles. Some add a new node beyond the current count.
    for (int c = 0; c < 12; c++) begin
      int n;
      n = pub_count;
      for (int id = 0; id < n; id++) do_txop(id, rand_claim(), n, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) do_txop($urandom_range(n, 60), 2'b11, n, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
